// File: rtl/single_pulse_capture.sv
// ---------------------------------------------------------------------------
// single_pulse_capture
//
// Measures one pulse on an asynchronous line relative to a start trigger.
// A falling edge on startclock arms the block and zeroes a timestamp
// counter. The block then records the cycle offsets of the next rising and
// falling edge of pulse_in. The captured start, end and width are held for
// host readback.
//
// Parameters
//   CNT_W        width of the timestamp counter and the captured values
//   SYNC_STAGES  synchronizer depth on startclock and on pulse_in (>= 2)
//   TIMEOUT      counter value at which an incomplete capture is abandoned
//
// Ports
//   clk          system clock; all logic is on the rising edge
//   rst_n        asynchronous active-low reset
//   startclock   asynchronous trigger; a falling edge starts a capture
//   pulse_in     asynchronous, active-high pulse under measurement
//   pulse1start  captured rising-edge offset  (tr - t0)
//   pulse1end    captured falling-edge offset (tf - t0)
//   pulse_width  pulse1end - pulse1start      (tf - tr)
//   valid        capture complete and results stable
//   timeout      last capture abandoned at TIMEOUT
//   busy         capture in progress
// ---------------------------------------------------------------------------
module single_pulse_capture #(
    parameter int unsigned       CNT_W       = 32,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0]  TIMEOUT     = CNT_W'(50000000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             startclock,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] pulse1start,
    output logic [CNT_W-1:0] pulse1end,
    output logic [CNT_W-1:0] pulse_width,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOW  = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        DONE      = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizers plus history flop (identical depth on both paths)
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [SYNC_STAGES-1:0] pulse_sync_q;
    logic                   start_hist_q;
    logic                   pulse_hist_q;

    logic start_lvl;
    logic pulse_lvl;

    assign start_lvl = start_sync_q[SYNC_STAGES-1];
    assign pulse_lvl = pulse_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= '0;
            pulse_sync_q <= '0;
            start_hist_q <= 1'b0;
            pulse_hist_q <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], startclock};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
            start_hist_q <= start_lvl;
            pulse_hist_q <= pulse_lvl;
        end
    end

    // -----------------------------------------------------------------------
    // Event pipeline: two register stages carrying the trigger strobe, the
    // pulse edge strobes and the pulse level side by side. Keeping all
    // events in lockstep means the trigger and pulse edges see exactly the
    // same delay, and the FSM acts SYNC_STAGES+2 edges after the pin
    // sample, which is what places valid at tf+SYNC_STAGES+2.
    // -----------------------------------------------------------------------
    logic trig_s1_q, rise_s1_q, fall_s1_q, lvl_s1_q;
    logic trig_s2_q, rise_s2_q, fall_s2_q, lvl_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q <= 1'b0;
            rise_s1_q <= 1'b0;
            fall_s1_q <= 1'b0;
            lvl_s1_q  <= 1'b0;
            trig_s2_q <= 1'b0;
            rise_s2_q <= 1'b0;
            fall_s2_q <= 1'b0;
            lvl_s2_q  <= 1'b0;
        end else begin
            trig_s1_q <= start_hist_q & ~start_lvl;
            rise_s1_q <= ~pulse_hist_q & pulse_lvl;
            fall_s1_q <= pulse_hist_q & ~pulse_lvl;
            lvl_s1_q  <= pulse_lvl;
            trig_s2_q <= trig_s1_q;
            rise_s2_q <= rise_s1_q;
            fall_s2_q <= fall_s1_q;
            lvl_s2_q  <= lvl_s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating increment of the timestamp counter
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Capture FSM with registered outputs
    //
    // The counter loads 1 (not 0) on the trigger: the FSM sees the trigger
    // and a pulse edge through the same pipeline, and a pulse edge read k
    // cycles after the load sees value 1+(k-1) = k, i.e. the exact offset.
    // The rising-edge stamp is held internally and only copied to the
    // outputs on completion, so a retrigger or timeout never exposes a
    // half-captured result.
    // -----------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] start_cap_q;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] end_q;
    logic [CNT_W-1:0] width_q;
    logic             valid_q;
    logic             timeout_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_cap_q <= '0;
            start_q     <= '0;
            end_q       <= '0;
            width_q     <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else if (trig_s2_q) begin
            // Trigger has priority over any pulse edge in the same cycle.
            cnt_q     <= CNT_W'(1);
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= lvl_s2_q ? WAIT_LOW : WAIT_RISE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // Results and flags held until the next trigger.
                end

                WAIT_LOW, WAIT_RISE, WAIT_FALL: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == TIMEOUT) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        case (state_q)
                            WAIT_LOW: begin
                                if (!lvl_s2_q) begin
                                    state_q <= WAIT_RISE;
                                end
                            end
                            WAIT_RISE: begin
                                if (rise_s2_q) begin
                                    start_cap_q <= cnt_q;
                                    state_q     <= WAIT_FALL;
                                end
                            end
                            WAIT_FALL: begin
                                if (fall_s2_q) begin
                                    start_q <= start_cap_q;
                                    end_q   <= cnt_q;
                                    width_q <= cnt_q - start_cap_q;
                                    valid_q <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= DONE;
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse1start = start_q;
    assign pulse1end   = end_q;
    assign pulse_width = width_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_single_pulse_capture.sv
// ---------------------------------------------------------------------------
// tb_single_pulse_capture
//
// Directed bench for single_pulse_capture (SYNC_STAGES=2, TIMEOUT=1000).
// Inputs are driven 1 time unit after a rising edge, so a value set while
// "ofs" equals k is first sampled at edge t0+k of the current capture.
// ---------------------------------------------------------------------------
module tb_single_pulse_capture;

    localparam int N = 2;

    logic        clk;
    logic        rst_n;
    logic        startclock;
    logic        pulse_in;
    logic [31:0] pulse1start;
    logic [31:0] pulse1end;
    logic [31:0] pulse_width;
    logic        valid;
    logic        timeout;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int ofs      = 0;

    single_pulse_capture #(
        .CNT_W       (32),
        .SYNC_STAGES (N),
        .TIMEOUT     (32'd1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .startclock  (startclock),
        .pulse_in    (pulse_in),
        .pulse1start (pulse1start),
        .pulse1end   (pulse1end),
        .pulse_width (pulse_width),
        .valid       (valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        ofs += n;
    endtask

    task automatic goto(input int k);
        if (k > ofs) tick(k - ofs);
    endtask

    // Raise startclock long enough to be seen high, then drop it; the next
    // edge is t0 of the new capture.
    task automatic trigger();
        startclock = 1'b1;
        tick(N + 3);
        startclock = 1'b0;
        ofs = 0;
    endtask

    task automatic chk_result(input string tag, input int s, input int e);
        chk({tag, "_start"}, pulse1start, s);
        chk({tag, "_end"},   pulse1end,   e);
        chk({tag, "_width"}, pulse_width, e - s);
    endtask

    // Check valid is low just before tf+N+2 and high (busy low) just after.
    task automatic chk_valid_edge(input string tag, input int tf);
        goto(tf + N + 2);
        chk({tag, "_valid_pre"}, valid, 0);
        tick(1);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        startclock = 1'b0;
        pulse_in   = 1'b0;
        tick(3);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_start", pulse1start, 0);
        rst_n = 1'b1;
        tick(3);

        // Basic capture: high from +100 to +350.
        trigger();
        goto(N + 2);
        chk("basic_busy_pre", busy, 0);
        tick(1);
        chk("basic_busy", busy, 1);
        goto(100); pulse_in = 1'b1;
        goto(350); pulse_in = 1'b0;
        chk_valid_edge("basic", 350);
        chk_result("basic", 100, 350);

        // Reset during WAIT_FALL clears everything asynchronously.
        trigger();
        goto(10); pulse_in = 1'b1;
        goto(30);
        chk("rstmid_busy", busy, 1);
        chk("rstmid_valid_cleared", valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy0", busy, 0);
        chk("rstmid_start0", pulse1start, 0);
        chk("rstmid_end0", pulse1end, 0);
        chk("rstmid_width0", pulse_width, 0);
        chk("rstmid_timeout0", timeout, 0);
        tick(2);
        rst_n = 1'b1;
        tick(5); pulse_in = 1'b0;
        tick(5); pulse_in = 1'b1;
        tick(5); pulse_in = 1'b0;
        tick(10);
        chk("notrig_valid", valid, 0);
        chk("notrig_busy", busy, 0);

        // Pulse already high at trigger is skipped.
        pulse_in = 1'b1;
        trigger();
        goto(5);  pulse_in = 1'b0;
        goto(20); pulse_in = 1'b1;
        goto(21); pulse_in = 1'b0;
        chk_valid_edge("prehigh", 21);
        chk_result("prehigh", 20, 21);

        // Retrigger in WAIT_RISE coinciding with a pulse rise: trigger wins.
        trigger();
        goto(8);  startclock = 1'b1;
        goto(12); startclock = 1'b0; pulse_in = 1'b1; ofs = 0;
        goto(3);  pulse_in = 1'b0;
        goto(9);  pulse_in = 1'b1;
        goto(11); pulse_in = 1'b0;
        chk_valid_edge("simul", 11);
        chk_result("simul", 9, 11);

        // Retrigger after a rise: first capture discarded.
        trigger();
        goto(10); pulse_in = 1'b1;
        goto(12); startclock = 1'b1;
        goto(15); startclock = 1'b0; ofs = 0;
        goto(5);  pulse_in = 1'b0;
        goto(30);
        chk("retrig_no_valid", valid, 0);
        chk("retrig_busy", busy, 1);
        goto(40); pulse_in = 1'b1;
        goto(60); pulse_in = 1'b0;
        chk_valid_edge("retrig", 60);
        chk_result("retrig", 40, 60);

        // Timeout: counter reaches 1000 with no pulse activity.
        trigger();
        goto(1000 + N + 2);
        chk("to_pre", timeout, 0);
        chk("to_busy_pre", busy, 1);
        tick(1);
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_valid", valid, 0);
        chk_result("to_hold", 40, 60);

        // Next trigger clears timeout as busy rises.
        trigger();
        goto(N + 2);
        chk("to_clr_pre", timeout, 1);
        tick(1);
        chk("to_clr", timeout, 0);
        chk("to_clr_busy", busy, 1);
        goto(7);  pulse_in = 1'b1;
        goto(12); pulse_in = 1'b0;
        chk_valid_edge("after_to", 12);
        chk_result("after_to", 7, 12);

        // Repeated captures; each trigger drops valid as busy rises.
        for (int i = 0; i < 3; i++) begin
            int r, f;
            r = 6 + i;
            f = r + 3 + 2 * i;
            trigger();
            goto(N + 2);
            chk("rep_valid_hold", valid, 1);
            tick(1);
            chk("rep_valid_clr", valid, 0);
            goto(r); pulse_in = 1'b1;
            goto(f); pulse_in = 1'b0;
            chk_valid_edge("rep", f);
            chk_result("rep", r, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
